// File: rtl/uart_rx_core_pkg.sv
// Shared UART receive definitions: data width, RX FSM states and status bit positions.
package uart_rx_core_pkg;

  localparam int UART_DATA_WIDTH = 8;

  // Bit positions inside the {overrun, frame_err} status word.
  localparam int STAT_OVR  = 1;
  localparam int STAT_FERR = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core_if.sv
// Write port from the UART receiver into the RX FIFO.
interface uart_rx_core_if;
  import uart_rx_core_pkg::*;

  logic [UART_DATA_WIDTH-1:0] wr_data;
  logic                       wren;
  logic                       fifo_full;

  // The receiver drives data and strobe; the FIFO reports when it is full.
  modport master (output wr_data, output wren, input fifo_full);
  modport slave  (input wr_data, input wren, output fifo_full);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  // Shift the raw input through two flops; both start at the line's idle level.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta <= RESET_VAL;
      q_o  <= RESET_VAL;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: oversamples rx_i, deserialises LSB first, pushes good
// bytes into the RX FIFO and keeps sticky overrun / framing error flags.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a low level on the synchronized line
//   START | counting to the middle of the start bit to reject glitches
//   DATA  | sampling 8 data bits, one every OVERSAMPLE ticks
//   STOP  | sampling the stop bit, then write / flag error and re-arm
//
// OVERSAMPLE must be even and at least 4.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        uart_clk_i,
  input  logic        rx_en_i,
  input  logic        rx_i,
  input  logic        stat_clr_i,
  output logic        rx_busy_o,
  output logic [1:0]  rx_stat_o,
  uart_rx_core_if.master bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(UART_DATA_WIDTH);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_WIDTH - 1);

  rx_state_e                  state;
  logic [CNT_W-1:0]           tick_cnt;
  logic [IDX_W-1:0]           bit_idx;
  logic [UART_DATA_WIDTH-1:0] shift;
  logic [UART_DATA_WIDTH-1:0] wr_data;
  logic                       wren;
  logic [1:0]                 stat;
  logic                       rx_sync;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (rx_i),
    .q_o    (rx_sync)
  );

  // Receive FSM with tick counter, shift register, write strobe and sticky status.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      wr_data  <= '0;
      wren     <= 1'b0;
      stat     <= 2'b00;
    end else begin
      wren <= 1'b0;
      // Clear first so that a set event later in this block overrides it.
      if (stat_clr_i) begin
        stat <= 2'b00;
      end
      if (!rx_en_i) begin
        // Disabling drops any partial byte silently.
        state    <= IDLE;
        tick_cnt <= '0;
        bit_idx  <= '0;
      end else if (uart_clk_i) begin
        case (state)
          IDLE: begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            if (!rx_sync) begin
              state <= START;
            end
          end
          START: begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              // A line back high at mid start bit was only a glitch.
              state    <= rx_sync ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt       <= '0;
              shift[bit_idx] <= rx_sync;
              if (bit_idx == IDX_LAST) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (!rx_sync) begin
                stat[STAT_FERR] <= 1'b1;
              end else if (bus.fifo_full) begin
                stat[STAT_OVR] <= 1'b1;
              end else begin
                wr_data <= shift;
                wren    <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign bus.wr_data = wr_data;
  assign bus.wren    = wren;
  assign rx_stat_o   = stat;
  assign rx_busy_o   = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core: 8N1 frames at OVERSAMPLE = 16 with a
// uart_clk_i strobe every fourth clk_i cycle.
module tb_uart_rx_core;

  logic       clk;
  logic       rstn;
  logic       uart_clk;
  logic       rx_en;
  logic       rx;
  logic       stat_clr;
  logic       rx_busy;
  logic [1:0] rx_stat;

  int checks = 0;
  int errors = 0;

  int         wr_count   = 0;
  int         misaligned = 0;
  logic [7:0] wr_log[$];
  logic       prev_tick  = 1'b0;

  uart_rx_core_if rx_bus ();

  uart_rx_core #(
    .OVERSAMPLE (16)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .uart_clk_i (uart_clk),
    .rx_en_i    (rx_en),
    .rx_i       (rx),
    .stat_clr_i (stat_clr),
    .rx_busy_o  (rx_busy),
    .rx_stat_o  (rx_stat),
    .bus        (rx_bus)
  );

  // 100 MHz system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oversample strobe: one cycle high out of every four.
  initial begin
    uart_clk = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 uart_clk = 1'b1;
      @(posedge clk);
      #1 uart_clk = 1'b0;
    end
  end

  // Log every cycle the write strobe is high and whether a tick preceded it.
  always @(negedge clk) begin
    if (rx_bus.wren === 1'b1) begin
      wr_count++;
      wr_log.push_back(rx_bus.wr_data);
      if (prev_tick !== 1'b1) misaligned++;
    end
    prev_tick = uart_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns 1 time unit after the next clk edge on which the strobe is high.
  task automatic wait_tick();
    @(posedge clk);
    while (uart_clk !== 1'b1) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (16) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (16 * n) wait_tick();
  endtask

  initial begin
    rstn     = 1'b0;
    rx       = 1'b1;
    rx_en    = 1'b1;
    stat_clr = 1'b0;
    rx_bus.fifo_full = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_data", 32'(rx_bus.wr_data), 32'h00);
    check("rst_wren", 32'(rx_bus.wren), 32'h0);
    check("rst_busy", 32'(rx_busy), 32'h0);
    check("rst_stat", 32'(rx_stat), 32'h0);
    rstn = 1'b1;
    wait_tick();
    idle_bits(1);

    // Frame 0x55 with the stop sample timed to the tick: start bit begins at
    // tick 0, detection at tick 1, stop sampled at tick 153.
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    rx = 1'b1;
    repeat (8) wait_tick();
    check("55_pre_stop_wren", 32'(rx_bus.wren), 32'h0);
    check("55_pre_stop_busy", 32'(rx_busy), 32'h1);
    wait_tick();
    check("55_wren_pulse", 32'(rx_bus.wren), 32'h1);
    check("55_wr_data", 32'(rx_bus.wr_data), 32'h55);
    check("55_rearm_idle", 32'(rx_busy), 32'h0);
    @(posedge clk);
    #1;
    check("55_wren_one_cycle", 32'(rx_bus.wren), 32'h0);
    repeat (7) wait_tick();
    idle_bits(1);
    check("55_wr_count", 32'(wr_count), 32'd1);
    check("55_stat", 32'(rx_stat), 32'h0);

    // Four-tick low glitch while idle.
    rx = 1'b0;
    repeat (4) wait_tick();
    rx = 1'b1;
    check("glitch_in_start", 32'(rx_busy), 32'h1);
    idle_bits(2);
    check("glitch_busy", 32'(rx_busy), 32'h0);
    check("glitch_wr_count", 32'(wr_count), 32'd1);
    check("glitch_stat", 32'(rx_stat), 32'h0);

    // Frame 0xA3 with a low stop bit, then clear.
    send_frame(8'hA3, 1'b0);
    idle_bits(2);
    check("ferr_wr_count", 32'(wr_count), 32'd1);
    check("ferr_stat", 32'(rx_stat), 32'h1);
    check("ferr_wr_data_held", 32'(rx_bus.wr_data), 32'h55);
    stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    check("ferr_cleared", 32'(rx_stat), 32'h0);
    wait_tick();

    // Frame 0x3C with the FIFO full; clear pulse lands on the set cycle.
    rx_bus.fifo_full = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(8'h3C >> i);
    rx = 1'b1;
    repeat (8) wait_tick();
    repeat (3) @(posedge clk);
    #1 stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    check("ovr_no_wren", 32'(rx_bus.wren), 32'h0);
    check("ovr_set_wins", 32'(rx_stat), 32'h2);
    rx_bus.fifo_full = 1'b0;
    repeat (7) wait_tick();
    idle_bits(1);
    check("ovr_wr_count", 32'(wr_count), 32'd1);
    check("ovr_stat_sticky", 32'(rx_stat), 32'h2);
    stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    check("ovr_cleared", 32'(rx_stat), 32'h0);
    wait_tick();

    // 0xF0 with rx_en dropped in the middle of data bit 3, then 0x81.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rx = 1'b0;
    repeat (8) wait_tick();
    rx_en = 1'b0;
    @(posedge clk);
    #1;
    check("dis_busy", 32'(rx_busy), 32'h0);
    wait_tick();
    repeat (7) wait_tick();
    for (int i = 4; i < 8; i++) send_bit(1'b1);
    send_bit(1'b1);
    check("dis_wr_count", 32'(wr_count), 32'd1);
    check("dis_stat", 32'(rx_stat), 32'h0);
    rx_en = 1'b1;
    idle_bits(1);
    send_frame(8'h81, 1'b1);
    idle_bits(1);
    check("en_wr_count", 32'(wr_count), 32'd2);
    check("en_data", 32'(wr_log[1]), 32'h81);
    check("en_stat", 32'(rx_stat), 32'h0);

    // Back-to-back 0x00 then 0xFF with no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_bits(1);
    check("b2b_wr_count", 32'(wr_count), 32'd4);
    check("b2b_first", 32'(wr_log[2]), 32'h00);
    check("b2b_second", 32'(wr_log[3]), 32'hFF);

    // Set overrun so the reset has something non-zero to clear.
    rx_bus.fifo_full = 1'b1;
    send_frame(8'h12, 1'b1);
    rx_bus.fifo_full = 1'b0;
    idle_bits(1);
    check("pre_rst_stat", 32'(rx_stat), 32'h2);

    // Reset in the middle of data bit 3 of 0x5A.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(8'h5A >> i);
    rx = 1'b1;
    repeat (8) wait_tick();
    rstn = 1'b0;
    #1;
    check("mid_rst_wr_data", 32'(rx_bus.wr_data), 32'h00);
    check("mid_rst_wren", 32'(rx_bus.wren), 32'h0);
    check("mid_rst_busy", 32'(rx_busy), 32'h0);
    check("mid_rst_stat", 32'(rx_stat), 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    wait_tick();
    idle_bits(2);
    check("mid_rst_no_write", 32'(wr_count), 32'd4);

    // Recovery after reset.
    send_frame(8'hC6, 1'b1);
    idle_bits(1);
    check("recover_wr_count", 32'(wr_count), 32'd5);
    check("recover_data", 32'(wr_log[4]), 32'hC6);
    check("recover_stat", 32'(rx_stat), 32'h0);
    check("wren_after_tick", 32'(misaligned), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Receive-side counterpart of the TX FIFO/UART path. Oversamples the asynchronous serial line `rx_i` and deserialises 8N1 frames, LSB first. Each good byte is pushed into the RX FIFO with a one-cycle write strobe. Framing and overrun errors are flagged in sticky status bits that the APB status register reads and clears.

## Interface
- `OVERSAMPLE`, default 16: `uart_clk_i` strobes per bit. Must be even and ≥4.
- `clk_i` input 1: system/APB clock; the only clock.
- `rstn_i` input 1: asynchronous, active-low reset.
- `uart_clk_i` input 1: oversample strobe; single-cycle pulse in the `clk_i` domain at OVERSAMPLE × baud.
- `rx_en_i` input 1: RX enable from the control register.
- `rx_i` input 1: asynchronous serial line; idles high.
- `fifo_full_i` input 1: RX FIFO full.
- `stat_clr_i` input 1: one-cycle pulse; clears the sticky error bits.
- `wr_data_o` output 8: received byte; valid while `wren_o` is high.
- `wren_o` output 1: RX FIFO write strobe, one `clk_i` cycle.
- `rx_busy_o` output 1: high in any state other than IDLE.
- `rx_stat_o` output 2: {overrun, frame_err}, both sticky.

## Operation
- `rx_i` passes through a 2-flop synchronizer. Both flops reset to 1.
- The FSM and the tick counter advance only on cycles where `uart_clk_i` is high. The tick counter is $clog2(OVERSAMPLE) bits wide.
- **IDLE**
  - Counter held at 0.
  - If the synchronized line is 0 and `rx_en_i` is 1, go to START.
- **START**
  - Count OVERSAMPLE/2 ticks to mid-bit, then resample.
  - Line 0: go to DATA, counter cleared, bit index 0.
  - Line 1: glitch; return to IDLE with no status change.
- **DATA**
  - Every OVERSAMPLE ticks, sample the line into the shift register at bit index, LSB first.
  - After bit 7, go to STOP.
- **STOP**
  - After OVERSAMPLE ticks, sample the line, then return to IDLE.
  - Stop = 1 and `fifo_full_i` = 0: `wr_data_o` ← byte, pulse `wren_o`.
  - Stop = 1 and `fifo_full_i` = 1: drop the byte, set overrun.
  - Stop = 0: drop the byte, set frame_err. `fifo_full_i` is ignored.
- `rx_en_i` low in any state: next cycle the FSM goes to IDLE and the partial byte is discarded. No write occurs and no status bit is set.
- Sticky bits are cleared only by `stat_clr_i`. If a set event and `stat_clr_i` occur in the same cycle, the set wins.
- Reset mid-frame aborts immediately. No partial write is ever emitted.

## Timing
- Reset values: `wr_data_o` = 8'h00, `wren_o` = 0, `rx_busy_o` = 0, `rx_stat_o` = 2'b00. FSM is in IDLE.
- Synchronizer latency is 2 `clk_i` cycles, from an `rx_i` edge to the value the FSM sees.
- `wren_o` is high exactly one `clk_i` cycle: the cycle after the `uart_clk_i` strobe on which the stop bit was sampled.
- `wr_data_o` is registered. It holds its value until the next write.
- Status bits update in the same cycle that `wren_o` would have pulsed.
- Re-arm: the FSM is back in IDLE the cycle after the stop sample. A start bit that immediately follows is detected, so back-to-back frames need no extra idle time.
- Mid-bit sample points fall at ticks OVERSAMPLE/2 + k·OVERSAMPLE after start detection, for k = 1..9.

## Structure
- Shared UART package holds:
  - `UART_DATA_WIDTH` = 8
  - RX state typedef or localparams: IDLE, START, DATA, STOP
  - `rx_stat_o` bit indices: OVR = 1, FERR = 0
- Sub-module `uart_rx_sync`: 2-flop synchronizer with a reset value parameter, here set to 1.
- Top-level integration (outside this block) mirrors the TX side:
  - `uart_rx_core` feeds a FIFO_ALL instance.
  - Status word is {rx_full, rx_empty, rx_stat_o}.

## Test plan
- Valid frame 0x55, OVERSAMPLE = 16, FIFO not full -> exactly one `wren_o` pulse with `wr_data_o` = 0x55, and `rx_stat_o` = 00.
- Low glitch on `rx_i` lasting 4 ticks while idle -> FSM returns to IDLE; no `wren_o`; `rx_stat_o` = 00.
- Frame 0xA3 with stop bit driven 0 -> no `wren_o`; `rx_stat_o` = 01. Then a `stat_clr_i` pulse -> 00.
- Frame 0x3C with `fifo_full_i` = 1 at the stop sample -> no `wren_o`; `rx_stat_o` = 10.
- `rx_en_i` dropped during data bit 3 of 0xF0, then re-enabled before the next frame 0x81 -> a single write of 0x81 only; status 00.
- Back-to-back frames 0x00 then 0xFF with no idle gap; also `rstn_i` asserted mid-frame -> writes of 0x00 then 0xFF; the reset aborts with all outputs at their reset values.
